// File: rtl/b08_sched_pkg.sv
// Shared types and constants for the b08 job scheduler.
package b08_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  localparam int DATA_W = 8;
  localparam int RES_W  = 4;

  // Ceiling log2, never below 1 so a 1-bit field always exists.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'd1 << i) < 32'(n)) r = i + 1;
      else r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/b08_job_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first eligible index after ptr, wrapping.
module rr_arbiter
  import b08_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = clog2(NREQ)
) (
  input  logic [NREQ-1:0]  eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from ptr+1 around to ptr; the first hit wins.
  always_comb begin : scan_p
    logic [IDX_W-1:0] k_s;
    logic             hit_s;
    k_s   = '0;
    hit_s = 1'b0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      k_s        = IDX_W'((int'(ptr) + i) % NREQ);
      hit_s      = eligible[k_s] & ~any;
      grant[k_s] = grant[k_s] | hit_s;
      idx        = hit_s ? k_s : idx;
      any        = any | hit_s;
    end
  end

endmodule

// File: rtl/b08_job_scheduler.sv
// Time-shares one b08 core between NREQ requesters with round-robin grants
// and a one-deep result buffer per requester.
module b08_job_scheduler
  import b08_sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int CORE_LAT = 11,
  parameter int CNT_W    = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [NREQ*RES_W-1:0]    rsp_data,
  input  logic [NREQ-1:0]          rsp_ready,
  output logic                     core_start,
  output logic [DATA_W-1:0]        core_i,
  input  logic [RES_W-1:0]         core_o,
  output logic                     busy,
  output logic [clog2(NREQ)-1:0]   grant_id,
  output logic [CNT_W-1:0]         jobs_done
);

  localparam int IDX_W = clog2(NREQ);
  localparam int WT_W  = clog2(CORE_LAT);

  state_t                  state_r, state_n_s;
  logic [WT_W-1:0]         wait_cnt_r;
  logic [IDX_W-1:0]        ptr_r, grant_id_r, win_idx_s;
  logic                    core_start_r, busy_r, win_any_s;
  logic [DATA_W-1:0]       core_i_r;
  logic [CNT_W-1:0]        jobs_done_r;
  logic [NREQ-1:0]         rsp_valid_r, rsp_valid_n_s, eligible_s, grant_s, cap_vec_s;
  logic [NREQ*RES_W-1:0]   rsp_data_r;

  // A requester still holding an unread result is not eligible.
  assign eligible_s = req_valid & ~rsp_valid_r;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .eligible (eligible_s),
    .ptr      (ptr_r),
    .grant    (grant_s),
    .idx      (win_idx_s),
    .any      (win_any_s)
  );

  // Next state, capture vector, response-valid update and accept strobe.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      IDLE:    state_n_s = win_any_s ? ISSUE : IDLE;
      ISSUE:   state_n_s = WAIT;
      WAIT:    state_n_s = (wait_cnt_r == WT_W'(32'd1)) ? CAPTURE : WAIT;
      CAPTURE: state_n_s = IDLE;
      default: state_n_s = IDLE;
    endcase
    cap_vec_s             = '0;
    cap_vec_s[grant_id_r] = (state_r == CAPTURE);
    rsp_valid_n_s         = (rsp_valid_r & ~rsp_ready) | cap_vec_s;
    req_ready             = (state_r == IDLE) ? grant_s : '0;
  end

  // State register, datapath latches, result buffers and job counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      wait_cnt_r   <= '0;
      ptr_r        <= IDX_W'(NREQ - 1);
      core_start_r <= 1'b0;
      core_i_r     <= '0;
      busy_r       <= 1'b0;
      grant_id_r   <= '0;
      jobs_done_r  <= '0;
      rsp_valid_r  <= '0;
      rsp_data_r   <= '0;
    end else begin
      state_r      <= state_n_s;
      core_start_r <= (state_n_s == ISSUE);
      busy_r       <= (state_n_s != IDLE);
      rsp_valid_r  <= rsp_valid_n_s;
      case (state_r)
        IDLE: begin
          if (win_any_s) begin
            core_i_r   <= req_data[DATA_W*win_idx_s +: DATA_W];
            grant_id_r <= win_idx_s;
            ptr_r      <= win_idx_s;
          end
        end
        ISSUE:   wait_cnt_r <= WT_W'(CORE_LAT - 1);
        WAIT:    wait_cnt_r <= wait_cnt_r - WT_W'(32'd1);
        CAPTURE: begin
          rsp_data_r[RES_W*grant_id_r +: RES_W] <= core_o;
          if (jobs_done_r != '1) jobs_done_r <= jobs_done_r + CNT_W'(32'd1);
        end
        default: wait_cnt_r <= wait_cnt_r;
      endcase
    end
  end

  assign core_start = core_start_r;
  assign core_i     = core_i_r;
  assign busy       = busy_r;
  assign grant_id   = grant_id_r;
  assign jobs_done  = jobs_done_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_data   = rsp_data_r;

endmodule

// File: tb/tb_b08_job_scheduler.sv
// Bench for b08_job_scheduler: job-level reference model plus a b08 core stand-in.
module tb_b08_job_scheduler;

  localparam int NREQ     = 4;
  localparam int CORE_LAT = 11;
  localparam int CNT_W    = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req_valid = '0, rsp_ready = '0;
  logic [NREQ*8-1:0] req_data = '0;
  logic [3:0]        core_o = 4'h0;

  logic [NREQ-1:0]   req_ready, rsp_valid;
  logic [NREQ*4-1:0] rsp_data;
  logic              core_start, busy;
  logic [7:0]        core_i;
  logic [1:0]        grant_id;
  logic [CNT_W-1:0]  jobs_done;

  logic [NREQ-1:0]   s_req_ready, s_rsp_valid;
  logic [NREQ*4-1:0] s_rsp_data;
  logic              s_core_start, s_busy;
  logic [7:0]        s_core_i;
  logic [1:0]        s_grant_id;
  logic [1:0]        s_jobs_done;

  always #5 clock = ~clock;

  b08_job_scheduler #(.NREQ(NREQ), .CORE_LAT(CORE_LAT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .core_start(core_start), .core_i(core_i),
    .core_o(core_o), .busy(busy), .grant_id(grant_id), .jobs_done(jobs_done)
  );

  // Narrow-counter build sharing all inputs; only its counter is checked.
  b08_job_scheduler #(.NREQ(NREQ), .CORE_LAT(CORE_LAT), .CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(s_req_ready), .rsp_valid(s_rsp_valid), .rsp_data(s_rsp_data),
    .rsp_ready(rsp_ready), .core_start(s_core_start), .core_i(s_core_i),
    .core_o(core_o), .busy(s_busy), .grant_id(s_grant_id), .jobs_done(s_jobs_done)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] elig, input int ptr);
    logic [1:0] kk;
    for (int i = 1; i <= NREQ; i++) begin
      kk = 2'((ptr + i) % NREQ);
      if (elig[kk]) return int'(kk);
    end
    return -1;
  endfunction

  // Job-level model: a job occupies ages 1..CORE_LAT+1 after its grant cycle.
  bit              model_ok = 1'b0;
  bit              m_active;
  int              m_age, m_owner, m_ptr, m_done, m_gid;
  logic [7:0]      m_core_i;
  logic [NREQ-1:0] m_pend;
  logic [3:0]      m_res [NREQ];
  int              core_due = -1;
  logic [3:0]      core_val = 4'h0;

  always @(negedge clock) begin
    logic [NREQ-1:0]   elig, exp_rdy, nxt_pend;
    logic [NREQ*4-1:0] exp_data;
    int                w, sat;
    // core stand-in: valid result exactly CORE_LAT cycles after core_start, noise otherwise
    core_o = (cyc == core_due) ? core_val : 4'($urandom);
    if (core_start === 1'b1) begin
      core_due = cyc + CORE_LAT;
      core_val = core_i[3:0] ^ 4'hA;
    end
    elig     = req_valid & ~m_pend;
    w        = m_active ? -1 : pick(elig, m_ptr);
    exp_rdy  = (w >= 0) ? (4'b0001 << w) : 4'b0000;
    exp_data = {m_res[3], m_res[2], m_res[1], m_res[0]};
    sat      = (m_done > 3) ? 3 : m_done;
    if (model_ok) begin
      check("req_ready",  32'(req_ready),  32'(exp_rdy));
      check("busy",       32'(busy),       32'(m_active));
      check("core_start", 32'(core_start), 32'(m_active && m_age == 1));
      check("core_i",     32'(core_i),     32'(m_core_i));
      check("grant_id",   32'(grant_id),   32'(m_gid));
      check("rsp_valid",  32'(rsp_valid),  32'(m_pend));
      check("rsp_data",   32'(rsp_data),   32'(exp_data));
      check("jobs_done",  32'(jobs_done),  32'(m_done));
      check("jobs_sat",   32'(s_jobs_done), 32'(sat));
    end
    if (reset) begin
      model_ok = 1'b1;
      m_active = 1'b0; m_age = 0; m_owner = 0; m_ptr = NREQ - 1;
      m_done = 0; m_gid = 0; m_core_i = 8'h00; m_pend = '0;
      for (int k = 0; k < NREQ; k++) m_res[k] = 4'h0;
      core_due = -1;
    end else begin
      nxt_pend = m_pend & ~rsp_ready;
      if (w >= 0) begin
        m_active = 1'b1; m_age = 1; m_owner = w; m_gid = w; m_ptr = w;
        m_core_i = req_data[8*w +: 8];
      end else if (m_active) begin
        if (m_age == CORE_LAT + 1) begin
          nxt_pend = nxt_pend | (4'b0001 << m_owner);
          m_res[m_owner] = m_core_i[3:0] ^ 4'hA;
          if (m_done < 65535) m_done++;
          m_active = 1'b0;
        end else begin
          m_age++;
        end
      end
      m_pend = nxt_pend;
    end
    cyc++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_pulse();
    step();
    reset = 1'b1; req_valid = '0; rsp_ready = '0;
    step();
    reset = 1'b0;
  endtask

  int n;
  int idx;
  int order[$];
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    repeat (3) step();
    reset = 1'b0;
    @(negedge clock);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_jobs_done", 32'(jobs_done), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_grant_id",  32'(grant_id),  32'd0);

    // single job, with req_data scrambled after the grant
    step();
    req_valid = 4'b0001; req_data[7:0] = 8'h5C;
    @(negedge clock);
    check("t1_ready", 32'(req_ready), 32'b0001);
    n = 0;
    while (!rsp_valid[0] && n < 40) begin
      step();
      req_data[7:0] = 8'($urandom);
      n++;
      @(negedge clock);
      if (n == 1) check("t1_core_start", 32'(core_start), 32'd1);
    end
    check("t1_latency",  32'(n), 32'd13);
    check("t1_rsp_data", 32'(rsp_data[3:0]), 32'h6);
    check("t1_jobs",     32'(jobs_done), 32'd1);
    step(); rsp_ready = 4'b0001;
    step(); rsp_ready = 4'b0000; req_valid = 4'b0000;

    // round-robin with all requesters busy and results drained at once
    reset_pulse();
    req_valid = 4'b1111; req_data = 32'h43322110; rsp_ready = 4'b1111;
    n = 0;
    while (order.size() < 5 && n < 100) begin
      @(negedge clock);
      idx = -1;
      for (int k = 0; k < NREQ; k++) if (req_ready == (4'b0001 << k)) idx = k;
      if (idx >= 0) order.push_back(idx);
      step();
      n++;
    end
    check("rr_count", 32'(order.size()), 32'd5);
    for (int i = 0; i < order.size(); i++) check("rr_order", 32'(order[i]), 32'(exp_order[i]));
    repeat (12) step();
    @(negedge clock);
    check("rr_jobs",    32'(jobs_done),   32'd5);
    check("rr_sat",     32'(s_jobs_done), 32'd3);
    check("rr_results", 32'(rsp_data),    32'h98BA);

    // pending result blocks requester 1 until consumed
    reset_pulse();
    req_valid = 4'b0010; req_data = $urandom; rsp_ready = 4'b0000;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (req_ready[1]) n++;
      step();
    end
    @(negedge clock);
    check("pend_grants", 32'(n), 32'd1);
    check("pend_busy",   32'(busy), 32'd0);
    check("pend_valid",  32'(rsp_valid), 32'b0010);
    step(); rsp_ready = 4'b0010;
    step(); rsp_ready = 4'b0000;
    @(negedge clock);
    check("pend_regrant", 32'(req_ready), 32'b0010);

    // reset in the middle of a wait
    reset_pulse();
    req_valid = 4'b1000;
    @(negedge clock);
    check("mid_first", 32'(req_ready), 32'b1000);
    repeat (6) step();
    reset = 1'b1; req_valid = 4'b1001;
    step();
    reset = 1'b0;
    @(negedge clock);
    check("mid_core_start", 32'(core_start), 32'd0);
    check("mid_rsp_valid",  32'(rsp_valid),  32'd0);
    check("mid_jobs",       32'(jobs_done),  32'd0);
    check("mid_busy",       32'(busy),       32'd0);
    check("mid_prio",       32'(req_ready),  32'b0001);

    // randomized traffic, occasional resets
    for (int i = 0; i < 800; i++) begin
      step();
      reset     = ($urandom_range(0, 299) == 0);
      req_valid = 4'($urandom);
      req_data  = $urandom;
      rsp_ready = 4'($urandom & $urandom);
    end
    step(); reset = 1'b0;
    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/b08_job_scheduler.md
Name: b08_job_scheduler

Overview:
- Shares one b08 pattern-match core between NREQ requesters.
- Round-robin arbitration among eligible requesters; drives core_start and core_i for the winner.
- Holds core_i stable for the whole scan, samples core_o after a fixed CORE_LAT cycles, and returns the 4-bit result through a 1-deep per-requester response buffer.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CORE_LAT, 11, cycles from the core_start cycle to the cycle core_o is valid (>=2).
- CNT_W, 16, width of jobs_done counter.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NREQ  request k presents a job.
- req_data  in  NREQ*8  job data; requester k on bits [8k+7:8k].
- req_ready  out  NREQ  one-hot accept; transfer on req_valid[k]&req_ready[k].
- rsp_valid  out  NREQ  result pending for requester k.
- rsp_data  out  NREQ*4  result; requester k on bits [4k+3:4k].
- rsp_ready  in  NREQ  requester k consumes result.
- core_start  out  1  start pulse to core.
- core_i  out  8  data to core.
- core_o  in  4  core result.
- busy  out  1  high in every state other than IDLE.
- grant_id  out  clog2(NREQ)  index of current or last owner.
- jobs_done  out  CNT_W  completed jobs, saturating at all-ones.

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Reset values: state IDLE, core_start 0, core_i 0, req_ready 0, rsp_valid 0, rsp_data 0, grant_id 0, jobs_done 0, busy 0. Round-robin pointer = NREQ-1, so requester 0 has first priority.
- Reset mid-job: the job is abandoned, pending results are discarded, and no capture occurs.
- Eligibility: eligible[k] = req_valid[k] & ~rsp_valid[k], using registered rsp_valid. A requester with a pending result cannot be granted.
- IDLE:
  - If any requester is eligible, the winner w is the first eligible index after the pointer, wrapping.
  - req_ready[w]=1 combinationally in this cycle; req_data[w] latches into core_i; grant_id<=w; pointer<=w; next state ISSUE.
  - If none is eligible, stay in IDLE with req_ready all zero.
- ISSUE:
  - core_start=1 for exactly this one cycle.
  - Wait counter loads CORE_LAT-1; next state WAIT.
- WAIT:
  - core_start=0; counter decrements each cycle.
  - When the counter reaches 1, next state CAPTURE.
  - WAIT therefore lasts CORE_LAT-1 cycles.
- CAPTURE: this cycle is exactly CORE_LAT cycles after the ISSUE cycle.
  - rsp_data[grant_id]<=core_o and rsp_valid[grant_id]<=1.
  - jobs_done increments, saturating.
  - Next state IDLE.
- core_i holds its value from ISSUE through CAPTURE and changes only on a new grant in IDLE.
- Response handshake:
  - rsp_valid[k] clears on the edge where rsp_valid[k]&rsp_ready[k].
  - rsp_data[k] holds its value until overwritten by the next capture for k.
  - rsp_ready while rsp_valid=0 is ignored.
  - Requester k becomes eligible the cycle after its consume.
- Throughput: minimum job period is CORE_LAT+2 cycles (IDLE + ISSUE + WAIT + CAPTURE). core_start is always separated by at least CORE_LAT+1 low cycles.
- Simultaneous events:
  - A consume for requester j in a CAPTURE cycle for requester i≠j: both take effect.
  - j==i cannot occur.
- req_valid dropped by a requester after arbitration has no effect; the transfer already happened in IDLE.
- No combinational path from core_o to any output.

Decomposition:
- Package b08_sched_pkg:
  - state enum {IDLE, ISSUE, WAIT, CAPTURE};
  - DATA_W=8, RES_W=4;
  - function clog2.
- Sub-module rr_arbiter:
  - inputs: eligible vector and pointer;
  - outputs: one-hot grant and encoded index;
  - purely combinational.

Test Plan:
- Single job: reset, then req_valid[0]=1, req_data=8'h5C; bench core model returns core_o=core_i[3:0]^4'hA after CORE_LAT -> req_ready[0] in cycle 1, core_start high only in cycle 2, rsp_valid[0]=1 with rsp_data[0]=4'h6 in the cycle after CAPTURE (cycle 13 with CORE_LAT=11), jobs_done=1.
- Round-robin: all four requesters valid continuously with data 8'h10,8'h21,8'h32,8'h43 and rsp_ready=1 -> grant order 0,1,2,3,0; core_start edges 13 cycles apart; results 4'hA,4'hB,4'h8,4'h9.
- Pending-result block: requester 1 holds rsp_ready=0 and keeps req_valid=1, requester 2 idle -> after its first job, requester 1 is not granted again; busy=0. Raise rsp_ready for one cycle -> requester 1 granted in the IDLE cycle after the consume.
- Reset mid-WAIT: assert reset at cycle 6 of a job -> next cycle core_start=0, rsp_valid=0, jobs_done=0, state IDLE. Requester 0 wins first after reset even if requester 3 is also valid.
- core_i stability: bench changes req_data[0] every cycle after the grant -> core_i keeps the accepted value until CAPTURE.
- Saturation: preload via CNT_W=2 build and run 5 jobs -> jobs_done stays at 2'b11.
